// File: rtl/inst_axi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : inst_axi_bridge                                                 |
// | Purpose  : Bridges an SRAM-style instruction fetch port onto an AXI read   |
// |            channel (AR/R). One single-beat read is issued per accepted     |
// |            request. Up to MAX_OUTSTANDING reads may be in flight, and the  |
// |            responses are returned in acceptance order.                     |
// | Ports    : clk, resetn (sync, active-low)                                  |
// |            inst_sram_*  : fetch request in; addr_ok/data_ok/rdata out      |
// |            ar*          : AXI read-address channel (master side)           |
// |            r*           : AXI read-data channel (master side)              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module inst_axi_bridge #(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] ARID_VAL        = 4'h0
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction SRAM-like port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // AXI AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [1:0] MAX_OUT = 2'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_t;

  ar_state_t   state;
  ar_state_t   state_next;
  logic [1:0]  outstanding;

  // Write-side data and the R-channel side info are not needed: every
  // response is a single in-order beat for a read we issued.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast};

  // Acceptance is only possible from idle, for reads, with room left.
  assign inst_sram_addr_ok = (state == AR_IDLE) & inst_sram_req & ~inst_sram_wr &
                             (outstanding < MAX_OUT);

  // R channel is a pure pass-through gated by having something in flight,
  // so stray beats after a reset are never acknowledged.
  assign rready            = (outstanding != 2'd0);
  assign inst_sram_data_ok = rvalid & rready;
  assign inst_sram_rdata   = rdata;

  assign arid    = ARID_VAL;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (state == AR_SEND);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= AR_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      AR_IDLE: if (inst_sram_addr_ok) state_next = AR_SEND;
      AR_SEND: if (arready)           state_next = AR_IDLE;
      default:                        state_next = AR_IDLE;
    endcase
  end

  // AR payload is captured at acceptance and held through AR_SEND.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      araddr <= 32'd0;
      arsize <= 3'd0;
    end else if (inst_sram_addr_ok) begin
      araddr <= inst_sram_addr;
      arsize <= {1'b0, inst_sram_size};
    end
  end

  // addr_ok is gated by the limit and data_ok by a nonzero count, so this
  // counter can neither overflow past MAX_OUT nor underflow.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      outstanding <= 2'd0;
    end else begin
      case ({inst_sram_addr_ok, inst_sram_data_ok})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_axi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_inst_axi_bridge                                              |
// | Purpose  : Directed self-checking bench for inst_axi_bridge with default   |
// |            parameters (MAX_OUTSTANDING=2, ARID_VAL=0).                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_inst_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_axi_bridge dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (req),
    .inst_sram_wr      (wr),
    .inst_sram_size    (size),
    .inst_sram_wstrb   (wstrb),
    .inst_sram_addr    (addr),
    .inst_sram_wdata   (wdata),
    .inst_sram_addr_ok (addr_ok),
    .inst_sram_data_ok (data_ok),
    .inst_sram_rdata   (sram_rdata),
    .arid              (arid),
    .araddr            (araddr),
    .arlen             (arlen),
    .arsize            (arsize),
    .arburst           (arburst),
    .arlock            (arlock),
    .arcache           (arcache),
    .arprot            (arprot),
    .arvalid           (arvalid),
    .arready           (arready),
    .rid               (rid),
    .rdata             (rdata),
    .rresp             (rresp),
    .rlast             (rlast),
    .rvalid            (rvalid),
    .rready            (rready)
  );

  // Advance one edge; inputs are changed 1ns after it and outputs are
  // sampled 1ns after that, well away from the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    #1;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %b exp 0", arvalid); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready got %b exp 0", rready); end
    checks++; if (addr_ok !== 1'b0) begin errors++; $display("FAIL reset_addr_ok got %b exp 0", addr_ok); end
    checks++; if (araddr !== 32'h0) begin errors++; $display("FAIL reset_araddr got %h exp 0", araddr); end
    checks++; if (arsize !== 3'h0) begin errors++; $display("FAIL reset_arsize got %h exp 0", arsize); end
    checks++; if ({arid, arlen, arburst, arlock, arcache, arprot} !== {4'h0, 8'h0, 2'b01, 2'b00, 4'h0, 3'h0})
      begin errors++; $display("FAIL const_ar got %h exp %h", {arid, arlen, arburst, arlock, arcache, arprot},
                               {4'h0, 8'h0, 2'b01, 2'b00, 4'h0, 3'h0}); end
    resetn = 1'b1;
    tick();
    #1;
    checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL post_reset_data_ok got %b exp 0", data_ok); end
  endtask

  task automatic test_single_fetch();
    req = 1'b1; addr = 32'h1c000000; size = 2'd2;
    #1;
    checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL single_addr_ok got %b exp 1", addr_ok); end
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL single_arvalid_c0 got %b exp 0", arvalid); end
    tick();
    req = 1'b0; arready = 1'b1;
    #1;
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL single_arvalid_c1 got %b exp 1", arvalid); end
    checks++; if (araddr !== 32'h1c000000) begin errors++; $display("FAIL single_araddr got %h exp 1c000000", araddr); end
    checks++; if (arsize !== 3'b010) begin errors++; $display("FAIL single_arsize got %b exp 010", arsize); end
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL single_rready got %b exp 1", rready); end
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h02800c06;
    #1;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL single_arvalid_c2 got %b exp 0", arvalid); end
    checks++; if (data_ok !== 1'b1) begin errors++; $display("FAIL single_data_ok got %b exp 1", data_ok); end
    checks++; if (sram_rdata !== 32'h02800c06) begin errors++; $display("FAIL single_rdata got %h exp 02800c06", sram_rdata); end
    tick();
    rvalid = 1'b0;
    #1;
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL single_drained got %b exp 0", rready); end
  endtask

  task automatic test_ar_backpressure();
    req = 1'b1; addr = 32'h10000040; size = 2'd2;
    #1;
    checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL bp_accept got %b exp 1", addr_ok); end
    tick();
    addr = 32'h20000000; arready = 1'b0;   // request stays up; must not be taken
    for (int i = 0; i < 4; i++) begin
      if (i == 3) arready = 1'b1;
      #1;
      checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL bp_arvalid[%0d] got %b exp 1", i, arvalid); end
      checks++; if (araddr !== 32'h10000040) begin errors++; $display("FAIL bp_araddr[%0d] got %h exp 10000040", i, araddr); end
      checks++; if (addr_ok !== 1'b0) begin errors++; $display("FAIL bp_addr_ok[%0d] got %b exp 0", i, addr_ok); end
      tick();
    end
    req = 1'b0; arready = 1'b0;
    #1;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL bp_arvalid_end got %b exp 0", arvalid); end
    rvalid = 1'b1; rdata = 32'h11112222;
    #1;
    checks++; if (data_ok !== 1'b1) begin errors++; $display("FAIL bp_data_ok got %b exp 1", data_ok); end
    tick();
    rvalid = 1'b0;
    #1;
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", rready); end
  endtask

  task automatic test_outstanding_limit();
    arready = 1'b1;
    req = 1'b1; addr = 32'h00000100;
    tick(); req = 1'b0; tick();                 // A issued, outstanding=1
    req = 1'b1; addr = 32'h00000104;
    #1;
    checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL lim_second got %b exp 1", addr_ok); end
    tick(); req = 1'b0; tick();                 // B issued, outstanding=2
    req = 1'b1; addr = 32'h00000108;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (addr_ok !== 1'b0) begin errors++; $display("FAIL lim_third_blocked[%0d] got %b exp 0", i, addr_ok); end
      tick();
    end
    rvalid = 1'b1; rdata = 32'hAAAA0001;
    #1;
    checks++; if (data_ok !== 1'b1) begin errors++; $display("FAIL lim_data_ok_a got %b exp 1", data_ok); end
    checks++; if (addr_ok !== 1'b0) begin errors++; $display("FAIL lim_still_full got %b exp 0", addr_ok); end
    tick();
    rvalid = 1'b0;
    #1;
    checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL lim_third_accept got %b exp 1", addr_ok); end
    tick();
    req = 1'b0;
    #1;
    checks++; if (araddr !== 32'h00000108) begin errors++; $display("FAIL lim_third_araddr got %h exp 00000108", araddr); end
    tick();
    arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rdata = 32'hBBBB0000 + 32'(i);
      #1;
      checks++; if (data_ok !== 1'b1 || sram_rdata !== 32'hBBBB0000 + 32'(i))
        begin errors++; $display("FAIL lim_drain[%0d] got %b/%h exp 1/%h", i, data_ok, sram_rdata, 32'hBBBB0000 + 32'(i)); end
      tick();
    end
    rvalid = 1'b0;
    #1;
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL lim_drained got %b exp 0", rready); end
  endtask

  task automatic test_simultaneous();
    arready = 1'b1;
    req = 1'b1; addr = 32'h00000200;
    tick(); req = 1'b0; tick();                 // outstanding=1, idle
    req = 1'b1; addr = 32'h00000204; rvalid = 1'b1; rdata = 32'hCAFE0001;
    #1;
    checks++; if ({addr_ok, data_ok} !== 2'b11) begin errors++; $display("FAIL sim_both got %b exp 11", {addr_ok, data_ok}); end
    tick();
    req = 1'b0; rvalid = 1'b0;
    #1;
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL sim_rready got %b exp 1", rready); end
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL sim_arvalid got %b exp 1", arvalid); end
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE0002;
    #1;
    checks++; if (data_ok !== 1'b1) begin errors++; $display("FAIL sim_last_data_ok got %b exp 1", data_ok); end
    tick();
    rvalid = 1'b0;
    #1;
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL sim_drained got %b exp 0", rready); end
  endtask

  task automatic test_write_rejected();
    req = 1'b1; wr = 1'b1; addr = 32'h00000300; arready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({addr_ok, arvalid} !== 2'b00) begin errors++; $display("FAIL wr_reject[%0d] got %b exp 00", i, {addr_ok, arvalid}); end
      tick();
    end
    req = 1'b0; wr = 1'b0; arready = 1'b0;
    #1;
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL wr_no_state got %b exp 0", rready); end
  endtask

  task automatic test_reset_midflight();
    req = 1'b1; addr = 32'h00000400; arready = 1'b0;
    tick();                                     // AR_SEND, outstanding=1
    req = 1'b0; resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    checks++; if ({arvalid, rready} !== 2'b00) begin errors++; $display("FAIL mid_reset got %b exp 00", {arvalid, rready}); end
    tick();
    rvalid = 1'b1; rdata = 32'hDEAD0000;
    #1;
    checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL mid_stray_data_ok got %b exp 0", data_ok); end
    tick();
    rvalid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; wstrb = 4'h0;
    addr = 32'h0; wdata = 32'h0; arready = 1'b0;
    rid = 4'h0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
    test_reset();
    test_single_fetch();
    test_ar_backpressure();
    test_outstanding_limit();
    test_simultaneous();
    test_write_rejected();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_axi_bridge.md
INST_AXI_BRIDGE -- requirements
Module: inst_axi_bridge

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 2, maximum accepted-but-unreturned read requests (legal range 1..3).
REQ-002 Parameter ARID_VAL, default 4'h0, constant AXI read ID.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset; synchronous, active-low.
REQ-005 inst_sram_req  input  1  instruction fetch request.
REQ-006 inst_sram_wr  input  1  write flag; must be 0 for a request to be accepted.
REQ-007 inst_sram_size  input  2  access size.
REQ-008 inst_sram_wstrb  input  4  unused.
REQ-009 inst_sram_addr  input  32  fetch address.
REQ-010 inst_sram_wdata  input  32  unused.
REQ-011 inst_sram_addr_ok  output  1  request accepted this cycle.
REQ-012 inst_sram_data_ok  output  1  read data valid this cycle.
REQ-013 inst_sram_rdata  output  32  returned instruction word.
REQ-014 arid  output  4, araddr  output  32, arlen  output  8, arsize  output  3, arburst  output  2, arlock  output  2, arcache  output  4, arprot  output  3: AXI AR payload.
REQ-015 arvalid  output  1, arready  input  1: AR handshake.
REQ-016 rid  input  4, rdata  input  32, rresp  input  2, rlast  input  1: AXI R payload.
REQ-017 rvalid  input  1, rready  output  1: R handshake.

Function
REQ-018 AR FSM has two states, AR_IDLE and AR_SEND, and resets to AR_IDLE.
REQ-019 inst_sram_addr_ok = (state==AR_IDLE) & inst_sram_req & ~inst_sram_wr & (outstanding < MAX_OUTSTANDING), combinational, same cycle as the request.
REQ-020 On addr_ok, the block latches addr and size into araddr and arsize (arsize = {1'b0, size}), and the FSM enters AR_SEND.
REQ-021 In AR_SEND, arvalid=1 and araddr/arsize stay stable until arvalid & arready; on that edge the FSM returns to AR_IDLE.
REQ-022 arvalid is 0 in AR_IDLE; the first AR beat appears the cycle after addr_ok.
REQ-023 Maximum acceptance rate is one request per two cycles; addr_ok is 0 in AR_SEND.
REQ-024 Constant outputs: arid=ARID_VAL, arlen=0, arburst=2'b01, arlock=0, arcache=0, arprot=0.
REQ-025 outstanding counter has width 2: +1 on addr_ok, -1 on data_ok, unchanged when both occur in the same cycle.
REQ-026 rready = (outstanding != 0).
REQ-027 inst_sram_data_ok = rvalid & rready, and inst_sram_rdata = rdata, both combinational pass-through.
REQ-028 Responses are returned in acceptance order; rid, rresp and rlast are ignored.
REQ-029 A request with inst_sram_wr=1 is never accepted (addr_ok=0) and causes no state change.
REQ-030 The counter never exceeds MAX_OUTSTANDING and never underflows; rvalid while outstanding==0 is not acknowledged.

Reset
REQ-031 When resetn=0 at an edge: state=AR_IDLE, outstanding=0, araddr=0, arsize=0.
REQ-032 Next cycle after reset: arvalid=0, rready=0, addr_ok=0, data_ok=0.
REQ-033 Reset asserted mid-transaction (AR_SEND or outstanding>0) discards all pending requests; responses that arrive later are not forwarded.

Verification
REQ-034 Single fetch: req, addr=0x1c000000, arready=1, rvalid with rdata=0x02800c06 two cycles later -> addr_ok cycle 0; arvalid/araddr=0x1c000000 cycle 1; data_ok=1 with rdata=0x02800c06; outstanding returns to 0.
REQ-035 AR backpressure: arready=0 for 3 cycles -> arvalid held 4 cycles with araddr constant; addr_ok=0 throughout AR_SEND.
REQ-036 Outstanding limit: two requests accepted with no R response -> third req sees addr_ok=0 until one data_ok; then accepted.
REQ-037 Simultaneous addr_ok and data_ok at outstanding=1 -> outstanding stays 1; rready stays 1.
REQ-038 Write request: req=1, wr=1 for 5 cycles -> addr_ok=0, arvalid=0 throughout.
REQ-039 Reset mid-flight: resetn low while in AR_SEND with outstanding=1 -> next cycle arvalid=0, rready=0; a later rvalid produces no data_ok.
